// File: rtl/dq_abc_pkg.sv
// ---------------------------------------------------------------------------
// dq_abc_pkg
// Shared definitions for the sequenced inverse Park / inverse Clarke block.
//   N, Q      : word width and fractional bits of the sign-magnitude format
//   SQRT3_2   : sqrt(3)/2 in that format
//   ONE_Q     : 1.0 in that format
//   state_t   : FSM state encoding (IDLE, then one state per sequencing step)
//   sm_neg      : sign-magnitude negate that never creates -0
//   sm_half_neg : -x/2 in sign-magnitude, used for the -alpha/2 term
// ---------------------------------------------------------------------------
package dq_abc_pkg;

   localparam int N = 24;
   localparam int Q = 12;

   localparam logic [N-1:0] SQRT3_2 = 24'h000DDB;
   localparam logic [N-1:0] ONE_Q   = 24'(1 << Q);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      S_DC = 4'd1,
      S_QS = 4'd2,
      S_DS = 4'd3,
      S_QC = 4'd4,
      S_SB = 4'd5,
      S_KB = 4'd6,
      S_B  = 4'd7,
      S_C  = 4'd8
   } state_t;

   // Flip the sign only when the magnitude is non-zero.
   function automatic logic [N-1:0] sm_neg(input logic [N-1:0] x);
      return {x[N-1] ^ (|x[N-2:0]), x[N-2:0]};
   endfunction

   // Halve the magnitude and negate; the result is negative only when x was
   // positive with a non-zero magnitude.
   function automatic logic [N-1:0] sm_half_neg(input logic [N-1:0] x);
      return {~x[N-1] & (|x[N-2:0]), 1'b0, x[N-2:1]};
   endfunction

endpackage

// File: rtl/qadd_.sv
// ---------------------------------------------------------------------------
// qadd_
// Combinational sign-magnitude adder.
//   i_a, i_b : operands, bit N-1 = sign, bits N-2:0 = magnitude
//   o_y      : sum; same-sign magnitudes wrap on overflow, an exact
//              cancellation of opposite signs yields +0
// ---------------------------------------------------------------------------
module qadd_ #(
   parameter int N = 24
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_y
);

   logic [N-2:0] w_sum;
   logic [N-2:0] w_a_minus_b;
   logic [N-2:0] w_b_minus_a;

   assign w_sum       = i_a[N-2:0] + i_b[N-2:0];
   assign w_a_minus_b = i_a[N-2:0] - i_b[N-2:0];
   assign w_b_minus_a = i_b[N-2:0] - i_a[N-2:0];

   always_comb begin
      o_y = '0;
      if (i_a[N-1] == i_b[N-1]) begin
         o_y = {i_a[N-1], w_sum};
      end else if (i_a[N-2:0] > i_b[N-2:0]) begin
         o_y = {i_a[N-1], w_a_minus_b};
      end else begin
         o_y = {i_b[N-1] & (|w_b_minus_a), w_b_minus_a};
      end
   end

endmodule

// File: rtl/qmult_.sv
// ---------------------------------------------------------------------------
// qmult_
// Combinational sign-magnitude Q-format multiplier.
//   i_a, i_b : operands, bit N-1 = sign, bits N-2:0 = magnitude
//   o_y      : product; magnitude truncated to bits N-2+Q:Q of the full
//              product, upper bits discarded (silent wrap)
// ---------------------------------------------------------------------------
module qmult_ #(
   parameter int N = 24,
   parameter int Q = 12
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_y
);

   logic [2*N-3:0] w_prod;
   logic           w_unused_bits;

   assign w_prod = {{(N-1){1'b0}}, i_a[N-2:0]} * {{(N-1){1'b0}}, i_b[N-2:0]};
   assign o_y    = {i_a[N-1] ^ i_b[N-1], w_prod[N-2+Q:Q]};

   // Fraction bits below Q and overflow bits above N-2+Q are dropped.
   assign w_unused_bits = ^{w_prod[2*N-3:N-1+Q], w_prod[Q-1:0]};

endmodule

// File: rtl/dq_abc_seq.sv
// ---------------------------------------------------------------------------
// dq_abc_seq
// Sequenced inverse Park + inverse Clarke: d/q and cos/sin -> phases A/B/C.
// One multiplier and one adder are time-shared over an 8-step FSM.
//   clk, rst_n      : clock (rising edge), async active-low reset
//   start           : request, sampled only in IDLE
//   CosQ, SinQ, d, q: inputs, latched when start is accepted
//   busy            : high while the FSM is in S_DC..S_C
//   done            : one-cycle pulse, A/B/C just updated (FSM back in IDLE)
//   A, B, C         : phase references, held between completions
// Handshake: start is a request with no ready; it is taken only when the FSM
// sits in IDLE (including the done cycle) and dropped otherwise.
// ---------------------------------------------------------------------------
module dq_abc_seq
   import dq_abc_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] CosQ,
   input  logic [N-1:0] SinQ,
   input  logic [N-1:0] d,
   input  logic [N-1:0] q,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] A,
   output logic [N-1:0] B,
   output logic [N-1:0] C
);

   state_t       r_state;
   logic [N-1:0] r_cos, r_sin, r_d, r_q;
   logic [N-1:0] r_r0, r_r1, r_al, r_be, r_ha;

   logic [N-1:0] w_mul_a, w_mul_b, w_mul_y;
   logic [N-1:0] w_add_a, w_add_b, w_add_y;

   qmult_ #(.N(N), .Q(Q)) u_mul (.i_a(w_mul_a), .i_b(w_mul_b), .o_y(w_mul_y));
   qadd_  #(.N(N))        u_add (.i_a(w_add_a), .i_b(w_add_b), .o_y(w_add_y));

   // Operand selection depends only on the state and registered values.
   always_comb begin
      w_mul_a = '0;
      w_mul_b = '0;
      w_add_a = '0;
      w_add_b = '0;
      case (r_state)
         S_DC: begin w_mul_a = r_d;  w_mul_b = r_cos;   end
         S_QS: begin w_mul_a = r_q;  w_mul_b = r_sin;   end
         S_DS: begin
            w_mul_a = r_d;  w_mul_b = r_sin;
            w_add_a = r_r0; w_add_b = sm_neg(r_r1);
         end
         S_QC: begin w_mul_a = r_q;  w_mul_b = r_cos;   end
         S_SB: begin w_add_a = r_r0; w_add_b = r_r1;    end
         S_KB: begin w_mul_a = r_be; w_mul_b = SQRT3_2; end
         S_B:  begin w_add_a = r_ha; w_add_b = r_r0;    end
         S_C:  begin w_add_a = r_ha; w_add_b = sm_neg(r_r0); end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         A       <= '0;
         B       <= '0;
         C       <= '0;
         r_cos   <= '0;
         r_sin   <= '0;
         r_d     <= '0;
         r_q     <= '0;
         r_r0    <= '0;
         r_r1    <= '0;
         r_al    <= '0;
         r_be    <= '0;
         r_ha    <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cos   <= CosQ;
                  r_sin   <= SinQ;
                  r_d     <= d;
                  r_q     <= q;
                  busy    <= 1'b1;
                  r_state <= S_DC;
               end
            end
            S_DC: begin r_r0 <= w_mul_y; r_state <= S_QS; end
            S_QS: begin r_r1 <= w_mul_y; r_state <= S_DS; end
            S_DS: begin
               r_al    <= w_add_y;   // alpha = d*cos - q*sin
               r_r0    <= w_mul_y;
               r_state <= S_QC;
            end
            S_QC: begin r_r1 <= w_mul_y; r_state <= S_SB; end
            S_SB: begin r_be <= w_add_y; r_state <= S_KB; end  // beta = d*sin + q*cos
            S_KB: begin
               r_r0    <= w_mul_y;       // sqrt3/2 * beta
               r_ha    <= sm_half_neg(r_al);
               r_state <= S_B;
            end
            S_B: begin B <= w_add_y; r_state <= S_C; end
            S_C: begin
               C       <= w_add_y;
               A       <= r_al;
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dq_abc_seq.sv
module tb_dq_abc_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [23:0] cos_q, sin_q, d_in, q_in;
   logic        busy, done;
   logic [23:0] a_out, b_out, c_out;

   int n_checks = 0;
   int n_pass   = 0;

   logic [71:0] exp_q[$];

   dq_abc_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .CosQ(cos_q), .SinQ(sin_q), .d(d_in), .q(q_in),
      .busy(busy), .done(done), .A(a_out), .B(b_out), .C(c_out)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [23:0] m_mul(input logic [23:0] a, input logic [23:0] b);
      logic [45:0] p;
      p = {23'b0, a[22:0]} * {23'b0, b[22:0]};
      return {a[23] ^ b[23], p[34:12]};
   endfunction

   function automatic logic [23:0] m_add(input logic [23:0] a, input logic [23:0] b);
      logic [22:0] m;
      if (a[23] == b[23]) begin
         m = a[22:0] + b[22:0];
         return {a[23], m};
      end else if (a[22:0] > b[22:0]) begin
         m = a[22:0] - b[22:0];
         return {a[23], m};
      end else begin
         m = b[22:0] - a[22:0];
         return {(m != 0) ? b[23] : 1'b0, m};
      end
   endfunction

   function automatic logic [23:0] m_neg(input logic [23:0] x);
      return (x[22:0] == 0) ? x : {~x[23], x[22:0]};
   endfunction

   function automatic logic [23:0] m_half(input logic [23:0] x);
      return {~x[23] & (x[22:0] != 0), 1'b0, x[22:1]};
   endfunction

   function automatic logic [71:0] model(input logic [23:0] dd, qq, cc, ss);
      logic [23:0] r0, r1, al, be, ha, bb, cv;
      r0 = m_mul(dd, cc);
      r1 = m_mul(qq, ss);
      al = m_add(r0, m_neg(r1));
      r0 = m_mul(dd, ss);
      r1 = m_mul(qq, cc);
      be = m_add(r0, r1);
      r0 = m_mul(be, 24'h000DDB);
      ha = m_half(al);
      bb = m_add(ha, r0);
      cv = m_add(ha, m_neg(r0));
      return {al, bb, cv};
   endfunction

   function automatic logic [23:0] rnd_val();
      return {1'($urandom_range(0, 1)), 10'b0, 13'($urandom_range(0, 'h1FFF))};
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_result(input string tag);
      logic [71:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s_sb: no expected entry queued, got A=%h B=%h C=%h",
                  tag, a_out, b_out, c_out);
         return;
      end
      e = exp_q.pop_front();
      check({tag, "_A"}, a_out, e[71:48]);
      check({tag, "_B"}, b_out, e[47:24]);
      check({tag, "_C"}, c_out, e[23:0]);
   endtask

   // ---------------- driver ----------------
   // Starts a run from IDLE, scrambles the inputs after acceptance, waits
   // (bounded) for done and checks latency, busy length and the result.
   task automatic do_run(input logic [23:0] dd, qq, cc, ss, input bit pulse, input string tag);
      int cyc;
      int busy_cnt;
      d_in = dd; q_in = qq; cos_q = cc; sin_q = ss;
      start = 1'b1;
      exp_q.push_back(model(dd, qq, cc, ss));
      @(posedge clk); #1;
      start = 1'b0;
      d_in = $urandom; q_in = $urandom; cos_q = $urandom; sin_q = $urandom;
      cyc = 1;
      busy_cnt = 0;
      while (!done && cyc < 20) begin
         if (busy) busy_cnt++;
         start = pulse && (cyc >= 2) && (cyc <= 5);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check({tag, "_latency"}, cyc, 9);
      check({tag, "_busy_cycles"}, busy_cnt, 8);
      check({tag, "_busy_in_done"}, busy, 0);
      check_result(tag);
   endtask

   task automatic idle_cycles(input int n, output int dones);
      dones = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n_done;
      int cyc;
      rst_n = 1'b0;
      start = 1'b0;
      cos_q = '0; sin_q = '0; d_in = '0; q_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_A", a_out, 0);
      check("rst_B", b_out, 0);
      check("rst_C", c_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: d = 1.0, cos = 1.0
      do_run(24'h001000, 24'h000000, 24'h001000, 24'h000000, 1'b0, "t1");
      check("t1_A_hand", a_out, 24'h001000);
      check("t1_B_hand", b_out, 24'h800800);
      check("t1_C_hand", c_out, 24'h800800);

      // 2: q = 1.0, cos = 1.0 (A must be +0)
      do_run(24'h000000, 24'h001000, 24'h001000, 24'h000000, 1'b0, "t2");
      check("t2_A_hand", a_out, 24'h000000);
      check("t2_B_hand", b_out, 24'h000DDB);
      check("t2_C_hand", c_out, 24'h800DDB);

      // 3: d = -1.0, cos = 1.0
      do_run(24'h801000, 24'h000000, 24'h001000, 24'h000000, 1'b0, "t3");
      check("t3_A_hand", a_out, 24'h801000);
      check("t3_B_hand", b_out, 24'h000800);
      check("t3_C_hand", c_out, 24'h000800);

      // 4: start pulsed while busy is ignored
      do_run(24'h000800, 24'h000400, 24'h000DDB, 24'h000800, 1'b1, "t4");
      idle_cycles(12, n_done);
      check("t4_extra_done", n_done, 0);
      check("t4_busy_after", busy, 0);

      // 5: reset during S_QC aborts the run
      d_in = 24'h001000; q_in = 24'h000800; cos_q = 24'h000800; sin_q = 24'h000DDB;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("t5_busy_before_rst", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_A", a_out, 0);
      check("t5_rst_B", b_out, 0);
      check("t5_rst_C", c_out, 0);
      exp_q.delete();
      #2;
      rst_n = 1'b1;
      idle_cycles(12, n_done);
      check("t5_no_done", n_done, 0);
      do_run(24'h000C00, 24'h800600, 24'h000B00, 24'h800700, 1'b0, "t5_after");

      // 6: start held high -> back-to-back runs every 9 cycles
      d_in = rnd_val(); q_in = rnd_val(); cos_q = rnd_val(); sin_q = rnd_val();
      exp_q.push_back(model(d_in, q_in, cos_q, sin_q));
      start = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         cyc = 1;
         if (k < 3) begin
            d_in = rnd_val(); q_in = rnd_val(); cos_q = rnd_val(); sin_q = rnd_val();
            exp_q.push_back(model(d_in, q_in, cos_q, sin_q));
         end
         while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
         end
         check("t6_period", cyc, 9);
         check_result("t6");
         if (k == 3) start = 1'b0;
         @(posedge clk); #1;
         check("t6_busy_next", busy, (k < 3) ? 1 : 0);
      end
      idle_cycles(10, n_done);
      check("t6_no_extra", n_done, 0);

      // random scoreboard runs, |values| < 2.0
      for (int i = 0; i < 20; i++) begin
         do_run(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b0, "rnd");
      end

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
